key_schedule_store: RTL

Word-serial AES key scheduler with an integrated round-key store. It expands a 128/192/256-bit cipher key into all Nr+1 round keys, one 32-bit word per clock, and holds them in an internal word memory. The cipher datapath then reads any round key by round index through a registered read port. The block sits between the key input and the round datapath, and it replaces per-round combinational expansion for designs that need random-order round-key access, such as decryption.

---
 rtl/key_schedule_store.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/key_schedule_store.sv
// key_schedule_store: word-serial AES key expansion (128/192/256) feeding an
// internal round-key memory with a registered, round-indexed read port.
// aes_sbox: AES forward S-box computed as GF(2^8) inverse plus affine map.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] acc;
        logic [7:0] b;
        p   = '0;
        acc = x;
        b   = m;
        for (int unsigned k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ acc;
            b   = b >> 1;
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // multiplicative inverse as x^254 (zero maps to zero)
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int unsigned k = 0; k < 6; k++) begin
            r = gmul(gmul(r, r), x);
        end
        return gmul(r, r);
    endfunction

    logic [7:0] inv;

    // inverse followed by the fixed affine transform
    always_comb begin
        inv = ginv(a);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module key_schedule_store #(
    parameter int KEY_SIZE = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         ready,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         rd_valid
);

    localparam int NK = KEY_SIZE / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] I_LAST_KEY = 6'(NK - 1);
    localparam logic [5:0] I_END      = 6'(NW);
    localparam logic [2:0] NK_M1      = 3'(NK - 1);
    localparam logic [3:0] NR_MAX     = 4'(NR);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;

    state_t state, state_nx;

    logic [255:0]      key_sr;   // latched key, shifted up one word per LOAD cycle
    logic [NK*32-1:0]  win;      // last Nk words; [31:0] = w[i-1], top word = w[i-Nk]
    logic [31:0]       mem [0:NW-1];
    logic [7:0]        rcon;
    logic [5:0]        i;
    logic [2:0]        imod;     // i mod Nk

    logic              accept;
    logic              wr_en;
    logic              finish;
    logic [31:0]       wr_word;
    logic [31:0]       prev;
    logic [31:0]       oldest;
    logic [31:0]       sub_in;
    logic [31:0]       sub_out;
    logic [31:0]       t;

    assign prev   = win[31:0];
    assign oldest = win[NK*32-1 -: 32];
    assign sub_in = (imod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_sbox sb0 (.a(sub_in[31:24]), .y(sub_out[31:24]));
    aes_sbox sb1 (.a(sub_in[23:16]), .y(sub_out[23:16]));
    aes_sbox sb2 (.a(sub_in[15:8]),  .y(sub_out[15:8]));
    aes_sbox sb3 (.a(sub_in[7:0]),   .y(sub_out[7:0]));

    // select the expansion term t for the current word index
    always_comb begin
        t = prev;
        if (imod == 3'd0) begin
            t = sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && imod == 3'd4) begin
            t = sub_out;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and per-cycle control decode
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        wr_en    = 1'b0;
        finish   = 1'b0;
        wr_word  = '0;
        case (state)
            IDLE, READY: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                wr_en   = 1'b1;
                wr_word = key_sr[255:224];
                if (i == I_LAST_KEY) state_nx = EXPAND;
            end
            EXPAND: begin
                // one extra cycle after the last write so done/ready land at edge Nw+1
                if (i == I_END) begin
                    finish   = 1'b1;
                    state_nx = READY;
                end else begin
                    wr_en   = 1'b1;
                    wr_word = oldest ^ t;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // expansion datapath: index, modulo counter, Rcon, window, status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sr <= '0;
            win    <= '0;
            rcon   <= 8'h01;
            i      <= '0;
            imod   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ready  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                key_sr <= key_in;
                i      <= '0;
                imod   <= '0;
                rcon   <= 8'h01;
                ready  <= 1'b0;
                busy   <= 1'b1;
            end
            if (wr_en) begin
                i      <= i + 6'd1;
                imod   <= (imod == NK_M1) ? 3'd0 : imod + 3'd1;
                win    <= {win[NK*32-33:0], wr_word};
                key_sr <= {key_sr[223:0], 32'h0};
                if (state == EXPAND && imod == 3'd0) begin
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end
            end
            if (finish) begin
                done  <= 1'b1;
                ready <= 1'b1;
                busy  <= 1'b0;
            end
        end
    end

    // round-key memory write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_en) mem[i] <= wr_word;
    end

    logic [5:0] base;
    assign base = {rd_round, 2'b00};

    // registered read port, gated by ready and a legal round index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
        end else if (ready && rd_round <= NR_MAX) begin
            rd_key   <= {mem[base], mem[base + 6'd1], mem[base + 6'd2], mem[base + 6'd3]};
            rd_valid <= 1'b1;
        end else begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
        end
    end

endmodule
